// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and defaults for the bit-serial adder controller.
// Revision 1.0
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/fa.sv
// fa: one-bit full adder cell.
// Revision 1.0
`default_nettype none

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one shared full adder over WIDTH bits, LSB first.
// Revision 1.0
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // A new request is only taken when no addition is in flight.
  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (state == ADD) && (cnt == LAST_BIT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (state == ADD) begin
        // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        sum   <= {fa_s, sum[WIDTH-1:1]};
        carry <= fa_co;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + 1'b1;
        if (last_bit) cout <= fa_co;
      end
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
// Revision 1.0
`default_nettype none

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  logic [8:0]  exp8_q[$];
  int          acc8_q[$];
  logic [16:0] exp16_q[$];
  int          acc16_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitors: done sampled on the falling edge. With accept at edge E0 the
  // last rising edge before the done cycle is E0+WIDTH.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      check("busy8_with_done", 64'(busy8), 64'd0);
      if (exp8_q.size() == 0) flag("unexpected_done8");
      else begin
        check("result8", 64'({cout8, sum8}), 64'(exp8_q.pop_front()));
        check("latency8", 64'(cyc), 64'(acc8_q.pop_front() + 8));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      check("busy16_with_done", 64'(busy16), 64'd0);
      if (exp16_q.size() == 0) flag("unexpected_done16");
      else begin
        check("result16", 64'({cout16, sum16}), 64'(exp16_q.pop_front()));
        check("latency16", 64'(cyc), 64'(acc16_q.pop_front() + 16));
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp);
    drive8(a, b, c);
    exp8_q.push_back(exp);
    acc8_q.push_back(cyc);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) flag({name, "_timeout"});
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;
    logic        rc;

    #1;
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_sum", 64'({cout8, sum8}), 64'd0);
    check("reset_sum16", 64'({cout16, sum16}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, expected values worked by hand.
    op8(8'h5A, 8'h3C, 1'b0, 9'h096); drain("op_5a_3c");
    op8(8'hFF, 8'h01, 1'b0, 9'h100); drain("op_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF); drain("op_ff_ff_1");

    // start re-pulsed mid-ADD must be ignored.
    op8(8'h12, 8'h34, 1'b0, 9'h046);
    repeat (2) @(posedge clk);
    #1 drive8(8'h01, 8'h01, 1'b0);
    drain("ignored_start");
    repeat (12) @(posedge clk);
    #1;

    // start held high across two operations.
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk); #1;
    exp8_q.push_back(9'h030); acc8_q.push_back(cyc);
    a8 = 8'h7F; b8 = 8'h01;
    repeat (9) @(posedge clk);
    #1;
    exp8_q.push_back(9'h080); acc8_q.push_back(cyc);
    start8 = 1'b0;
    drain("held_start");

    // Asynchronous reset in the middle of an addition.
    drive8(8'hAA, 8'h55, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    op8(8'hC8, 8'h64, 1'b1, 9'h12D); drain("after_reset");

    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
      op8(ra8, rb8, rc, 9'(ra8) + 9'(rb8) + 9'(rc));
      drain("sweep8");
    end

    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rc = 1'($urandom);
      start16 = 1'b1; a16 = ra16; b16 = rb16; cin16 = rc;
      @(posedge clk); #1;
      start16 = 1'b0;
      exp16_q.push_back(17'(ra16) + 17'(rb16) + 17'(rc));
      acc16_q.push_back(cyc);
      drain("sweep16");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
